// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: round-robin door arbitration, vent/pump countdowns, door open commands.
// Optional door-open timeout enabled by defining AIRLOCK_TIMEOUT_EN.
module airlock_sequencer #(
  parameter int EVAC_CYCLES  = 8,
  parameter int PRESS_CYCLES = 8,
  parameter int CW           = 4,
  parameter int DOOR_TIMEOUT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic outer_req,
  input  logic inner_req,
  input  logic outer_closed,
  input  logic inner_closed,
  output logic vent_on,
  output logic pump_on,
  output logic outer_open,
  output logic inner_open,
  output logic pressurized,
  output logic evacuated,
  output logic busy,
  output logic door_timeout
);

  typedef enum logic [2:0] {
    IDLE_P  = 3'd0,
    IDLE_E  = 3'd1,
    EVAC    = 3'd2,
    PRESS   = 3'd3,
    OPEN_O  = 3'd4,
    OPEN_I  = 3'd5,
    CLOSE_O = 3'd6,
    CLOSE_I = 3'd7
  } state_t;

  localparam logic [CW-1:0] EVAC_LD  = CW'(EVAC_CYCLES - 1);
  localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rr_outer, rr_nxt;
  logic          doors_closed;
  logic          grant_outer, grant_inner;
  logic          to_fire;
  logic          forced_close;

  assign doors_closed = outer_closed & inner_closed;
  // rr_outer=1 means outer wins a tie; it always points away from the side just granted
  assign grant_outer  = outer_req & (~inner_req | rr_outer);
  assign grant_inner  = inner_req & (~outer_req | ~rr_outer);

`ifdef AIRLOCK_TIMEOUT_EN
  localparam int TW = $clog2(DOOR_TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign to_fire = (tcnt == TW'(DOOR_TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tcnt         <= '0;
      door_timeout <= 1'b0;
    end else begin
      door_timeout <= forced_close;
      if ((state_nxt == OPEN_O || state_nxt == OPEN_I) && state_nxt == state)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
    end
  end
`else
  wire logic unused_timeout = (DOOR_TIMEOUT > 0);
  assign to_fire      = 1'b0;
  assign door_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rr_nxt       = rr_outer;
    forced_close = 1'b0;
    case (state)
      IDLE_P: begin
        if (grant_inner) begin
          state_nxt = OPEN_I;
          rr_nxt    = 1'b1;
        end else if (grant_outer) begin
          state_nxt = EVAC;
          cnt_nxt   = EVAC_LD;
          rr_nxt    = 1'b0;
        end
      end
      IDLE_E: begin
        if (grant_outer) begin
          state_nxt = OPEN_O;
          rr_nxt    = 1'b0;
        end else if (grant_inner) begin
          state_nxt = PRESS;
          cnt_nxt   = PRESS_LD;
          rr_nxt    = 1'b1;
        end
      end
      // An open door pauses the phase without restarting it
      EVAC: begin
        if (doors_closed) begin
          if (cnt == '0) state_nxt = OPEN_O;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      PRESS: begin
        if (doors_closed) begin
          if (cnt == '0) state_nxt = OPEN_I;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      OPEN_O: begin
        if (!outer_req || to_fire) state_nxt = CLOSE_O;
        forced_close = outer_req & to_fire;
      end
      OPEN_I: begin
        if (!inner_req || to_fire) state_nxt = CLOSE_I;
        forced_close = inner_req & to_fire;
      end
      CLOSE_O: if (outer_closed) state_nxt = IDLE_E;
      CLOSE_I: if (inner_closed) state_nxt = IDLE_P;
      default: state_nxt = IDLE_P;
    endcase
  end

  // Outputs are registered from the next state so no input reaches an output combinationally
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE_P;
      cnt         <= '0;
      rr_outer    <= 1'b1;
      vent_on     <= 1'b0;
      pump_on     <= 1'b0;
      outer_open  <= 1'b0;
      inner_open  <= 1'b0;
      pressurized <= 1'b1;
      evacuated   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rr_outer    <= rr_nxt;
      vent_on     <= (state_nxt == EVAC) & doors_closed;
      pump_on     <= (state_nxt == PRESS) & doors_closed;
      outer_open  <= (state_nxt == OPEN_O);
      inner_open  <= (state_nxt == OPEN_I);
      pressurized <= (state_nxt == IDLE_P) || (state_nxt == OPEN_I) || (state_nxt == CLOSE_I);
      evacuated   <= (state_nxt == IDLE_E) || (state_nxt == OPEN_O) || (state_nxt == CLOSE_O);
      busy        <= !((state_nxt == IDLE_P) || (state_nxt == IDLE_E));
    end
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed table-driven bench for airlock_sequencer with EVAC/PRESS = 4 cycles,
// plus a held-request sequence exercising the door-open timeout (or its absence).
module tb_airlock_sequencer;

  logic Clock = 1'b0;
  logic Reset;
  logic outer_req, inner_req, outer_closed, inner_closed;
  logic vent_on, pump_on, outer_open, inner_open;
  logic pressurized, evacuated, busy, door_timeout;

  airlock_sequencer #(
    .EVAC_CYCLES (4),
    .PRESS_CYCLES(4),
    .CW          (4),
    .DOOR_TIMEOUT(16)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .outer_req   (outer_req),
    .inner_req   (inner_req),
    .outer_closed(outer_closed),
    .inner_closed(inner_closed),
    .vent_on     (vent_on),
    .pump_on     (pump_on),
    .outer_open  (outer_open),
    .inner_open  (inner_open),
    .pressurized (pressurized),
    .evacuated   (evacuated),
    .busy        (busy),
    .door_timeout(door_timeout)
  );

  always #5 Clock = ~Clock;

  // Output bundle: {vent, pump, outer_open, inner_open, pressurized, evacuated, busy, door_timeout}
  localparam logic [7:0] IDP = 8'b0000_1000;
  localparam logic [7:0] IDE = 8'b0000_0100;
  localparam logic [7:0] EVV = 8'b1000_0010;
  localparam logic [7:0] EVP = 8'b0000_0010;
  localparam logic [7:0] PRP = 8'b0100_0010;
  localparam logic [7:0] OPO = 8'b0010_0110;
  localparam logic [7:0] OPI = 8'b0001_1010;
  localparam logic [7:0] CLO = 8'b0000_0110;
  localparam logic [7:0] CLI = 8'b0000_1010;

  typedef struct {
    logic       rst;
    logic       oreq;
    logic       ireq;
    logic       oc;
    logic       ic;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic void add(input logic r, input logic o, input logic i,
                              input logic oc, input logic ic, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.oreq = o; v.ireq = i; v.oc = oc; v.ic = ic; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] outs();
    return {vent_on, pump_on, outer_open, inner_open, pressurized, evacuated, busy, door_timeout};
  endfunction

  task automatic drive(input logic r, input logic o, input logic i, input logic oc, input logic ic);
    Reset = r; outer_req = o; inner_req = i; outer_closed = oc; inner_closed = ic;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int run;
    int dto_seen;
    int dto_at_drop;

    Reset = 1'b1; outer_req = 1'b0; inner_req = 1'b0; outer_closed = 1'b1; inner_closed = 1'b1;

    // reset, matching inner request, close
    add(1,0,0,1,1,IDP); add(0,0,1,1,1,OPI); add(0,0,1,1,1,OPI);
    add(0,0,0,1,0,CLI); add(0,0,0,1,0,CLI); add(0,0,0,1,1,IDP);
    // cross outer request: 4 vent cycles, open, close to IDLE_E
    add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV);
    add(0,1,0,1,1,OPO); add(0,0,0,0,1,CLO); add(0,0,0,1,1,IDE);
    // cross inner request: 4 pump cycles
    add(0,0,1,1,1,PRP); add(0,0,1,1,1,PRP); add(0,0,1,1,1,PRP); add(0,0,1,1,1,PRP);
    add(0,0,1,1,1,OPI); add(0,0,0,1,0,CLI); add(0,0,0,1,1,IDP);
    // EVAC paused 3 cycles by inner door; request dropped mid-phase still completes
    add(0,1,0,1,1,EVV); add(0,1,0,1,0,EVP); add(0,1,0,1,0,EVP); add(0,1,0,1,0,EVP);
    add(0,1,0,1,1,EVV); add(0,0,0,1,1,EVV); add(0,0,0,1,1,EVV);
    add(0,0,0,1,1,OPO); add(0,0,0,1,1,CLO); add(0,0,0,1,1,IDE);
    // both requests after reset: outer first, then inner, then outer again
    add(1,0,0,1,1,IDP);
    add(0,1,1,1,1,EVV); add(0,1,1,1,1,EVV); add(0,1,1,1,1,EVV); add(0,1,1,1,1,EVV);
    add(0,1,1,1,1,OPO); add(0,0,1,1,1,CLO); add(0,0,1,1,1,IDE);
    add(0,1,1,1,1,PRP); add(0,1,1,1,1,PRP); add(0,1,1,1,1,PRP); add(0,1,1,1,1,PRP);
    add(0,1,1,1,1,OPI); add(0,1,0,1,1,CLI); add(0,1,0,1,1,IDP);
    add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV); add(0,1,0,1,1,EVV);
    add(0,1,0,1,1,OPO); add(0,0,1,1,1,CLO); add(0,0,1,1,1,IDE);
    // reset mid-PRESS with counter at 2
    add(0,0,1,1,1,PRP); add(0,0,1,1,1,PRP); add(1,0,1,1,1,IDP); add(0,0,0,1,1,IDP);

    @(negedge Clock);
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].oreq, vecs[k].ireq, vecs[k].oc, vecs[k].ic);
      nvec++;
      if (outs() !== vecs[k].exp) begin
        nerr++;
        $display("FAIL vec%0d: outputs got %b, want %b", k, outs(), vecs[k].exp);
      end
    end

    // Held inner request: measure how long inner_open stays up (bounded at 40 cycles)
    drive(1,0,0,1,1);
    check("timeout_reset_io", int'(inner_open), 0);
    drive(0,0,1,1,1);
    run = 0; dto_seen = 0;
    while (inner_open && run < 40) begin
      run++;
      if (door_timeout) dto_seen++;
      @(negedge Clock);
    end
    dto_at_drop = int'(door_timeout);
    check("dto_while_open", dto_seen, 0);
`ifdef AIRLOCK_TIMEOUT_EN
    check("open_cycles", run, 16);
    check("dto_pulse", dto_at_drop, 1);
    @(negedge Clock);
    check("dto_one_cycle", int'(door_timeout), 0);
`else
    check("open_cycles", run, 40);
    check("dto_tied", dto_at_drop, 0);
`endif
    drive(0,0,0,1,1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
